// File: rtl/bus_master_if.sv
// bus_master_if: master-side load/store port in front of the bus arbiter.
// One request at a time: request, grant, one AS/RDY cycle, hold result.
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_err,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    HOLD
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t state, state_n;

  logic [7:0]        cnt, cnt_n;
  logic              req_n;
  logic              as_n;
  logic              rw_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wd_n;
  logic [DATA_W-1:0] rd_n;
  logic              err_n;

  // Stall the core while a request is being accepted or is on the bus.
  assign busy = (state == IDLE && core_req && !flush)
              || state == REQ
              || state == ACCESS;

  // Next state and next values of all registered bus/core outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = bus_req_;
    as_n    = bus_as_;
    rw_n    = bus_rw;
    addr_n  = bus_addr;
    wd_n    = bus_wr_data;
    rd_n    = core_rd_data;
    err_n   = core_err;
    unique case (state)
      IDLE: begin
        if (core_req && !flush) begin
          addr_n  = core_addr;
          rw_n    = core_rw;
          wd_n    = core_wr_data;
          req_n   = 1'b0;
          state_n = REQ;
        end
      end
      REQ: begin
        req_n = 1'b0;
        if (flush) begin
          req_n   = 1'b1;
          state_n = IDLE;
        end else if (!bus_grnt_) begin
          as_n    = 1'b0;
          cnt_n   = 8'd0;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        // Strobe lasts one cycle; grant and flush cannot abort the cycle.
        as_n = 1'b1;
        if (!bus_rdy_) begin
          if (bus_rw) begin
            rd_n = bus_rd_data;
          end
          err_n   = 1'b0;
          req_n   = 1'b1;
          state_n = HOLD;
        end else if (cnt == TO) begin
          err_n   = 1'b1;
          rd_n    = '0;
          req_n   = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (!stall || flush) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      bus_req_     <= 1'b1;
      bus_as_      <= 1'b1;
      bus_rw       <= 1'b1;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      core_rd_data <= '0;
      core_err     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bus_req_     <= req_n;
      bus_as_      <= as_n;
      bus_rw       <= rw_n;
      bus_addr     <= addr_n;
      bus_wr_data  <= wd_n;
      core_rd_data <= rd_n;
      core_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed + randomized accesses against a
// transaction-level model of the request/grant/strobe/ready protocol.
module tb_bus_master_if;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          core_req;
  logic          core_rw;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wr_data;
  logic [DW-1:0] core_rd_data;
  logic          core_err;
  logic          busy;
  logic          bus_req_;
  logic          bus_grnt_;
  logic          bus_as_;
  logic          bus_rw;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_rdy_;

  bus_master_if #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .core_req    (core_req),
    .core_rw     (core_rw),
    .core_addr   (core_addr),
    .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data),
    .core_err    (core_err),
    .busy        (busy),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;

  // transaction-level model state
  logic [DW-1:0] m_rd;
  logic          m_err;
  logic [AW-1:0] m_addr;
  logic          m_rw;
  logic [DW-1:0] m_wd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag);
    chk({tag, "_addr"}, 64'(bus_addr), 64'(m_addr));
    chk({tag, "_rw"}, 64'(bus_rw), 64'(m_rw));
    chk({tag, "_wd"}, 64'(bus_wr_data), 64'(m_wd));
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_rd"}, 64'(core_rd_data), 64'(m_rd));
    chk({tag, "_err"}, 64'(core_err), 64'(m_err));
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 64'(bus_req_), 1);
    chk("rst_as", 64'(bus_as_), 1);
    chk("rst_busy", 64'(busy), 0);
    chk_bus("rst");
    chk_res("rst");
  endtask

  // One access: gd REQ cycles without grant, ready on ACCESS cycle rd,
  // hold HOLD cycles (stall high on all but the last). freq/racc pick a
  // REQ/ACCESS cycle for flush/reset (-1 = none).
  task automatic access(input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] w, input logic [DW-1:0] rdv,
                        input int gd, input int rd, input int hold,
                        input bit hflush, input int freq, input bit facc,
                        input int racc);
    int n;
    bit ok;
    logic [DW-1:0] cap;
    cap = '0;
    busy_cycles = 0;
    core_req = 1'b1;
    core_rw = rw;
    core_addr = a;
    core_wr_data = w;
    flush = 1'b0;
    stall = 1'b0;
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b1;
    bus_rd_data = DW'($urandom);
    #1;
    if (busy) busy_cycles++;
    chk("c0_busy", 64'(busy), 1);
    chk("c0_req", 64'(bus_req_), 1);
    chk("c0_as", 64'(bus_as_), 1);
    m_addr = a;
    m_rw = rw;
    m_wd = w;
    step();
    for (int k = 0; k <= gd; k++) begin
      core_req = 1'($urandom);
      core_rw = 1'($urandom);
      core_addr = AW'($urandom);
      core_wr_data = DW'($urandom);
      bus_grnt_ = (k >= gd) ? 1'b0 : 1'b1;
      flush = (k == freq);
      #1;
      if (busy) busy_cycles++;
      chk("req_busy", 64'(busy), 1);
      chk("req_req", 64'(bus_req_), 0);
      chk("req_as", 64'(bus_as_), 1);
      chk_bus("req");
      chk_res("req");
      step();
      if (k == freq) begin
        core_req = 1'b0;
        flush = 1'b0;
        bus_grnt_ = 1'b1;
        #1;
        chk("fl_busy", 64'(busy), 0);
        chk("fl_req", 64'(bus_req_), 1);
        chk("fl_as", 64'(bus_as_), 1);
        chk_bus("fl");
        chk_res("fl");
        step();
        return;
      end
    end
    ok = (rd <= TO);
    n = ok ? rd + 1 : TO + 1;
    for (int j = 0; j < n; j++) begin
      core_req = 1'($urandom);
      core_rw = 1'($urandom);
      core_addr = AW'($urandom);
      core_wr_data = DW'($urandom);
      bus_grnt_ = 1'($urandom);
      flush = facc;
      bus_rdy_ = (j == rd) ? 1'b0 : 1'b1;
      bus_rd_data = (j == rd) ? rdv : DW'($urandom);
      if (j == rd) cap = rdv;
      if (j == racc) begin
        reset = 1'b1;
        core_req = 1'b0;
        flush = 1'b0;
        step();
        reset = 1'b0;
        bus_rdy_ = 1'b1;
        m_rd = '0;
        m_err = 1'b0;
        m_addr = '0;
        m_rw = 1'b1;
        m_wd = '0;
        #1;
        chk_reset_vals();
        step();
        return;
      end
      #1;
      if (busy) busy_cycles++;
      chk("acc_busy", 64'(busy), 1);
      chk("acc_req", 64'(bus_req_), 0);
      chk("acc_as", 64'(bus_as_), (j == 0) ? 64'd0 : 64'd1);
      chk_bus("acc");
      chk_res("acc");
      step();
    end
    if (ok) begin
      if (rw) m_rd = cap;
      m_err = 1'b0;
    end else begin
      m_rd = '0;
      m_err = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      stall = (h < hold - 1) || hflush;
      flush = hflush && (h == hold - 1);
      core_req = 1'b1;
      core_addr = AW'($urandom);
      bus_rdy_ = 1'b1;
      bus_grnt_ = 1'($urandom);
      bus_rd_data = DW'($urandom);
      #1;
      chk("hold_busy", 64'(busy), 0);
      chk("hold_req", 64'(bus_req_), 1);
      chk("hold_as", 64'(bus_as_), 1);
      chk_bus("hold");
      chk_res("hold");
      step();
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    core_req = 1'b0;
    core_rw = 1'b0;
    core_addr = '0;
    core_wr_data = '0;
    bus_grnt_ = 1'b1;
    bus_rd_data = '0;
    bus_rdy_ = 1'b1;
    m_rd = '0;
    m_err = 1'b0;
    m_addr = '0;
    m_rw = 1'b1;
    m_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals();
    step();

    // read, immediate grant and ready
    access(1'b1, AW'(32'h10), '0, 32'hDEAD_BEEF, 0, 0, 1, 0, -1, 0, -1);
    chk("rd_deadbeef", 64'(core_rd_data), 64'h0000_0000_DEAD_BEEF);
    chk("rd_busy_len", 64'(busy_cycles), 3);

    // write, grant and ready each late by two cycles
    access(1'b0, AW'($urandom), 32'h1234_5678, DW'($urandom),
           2, 2, 1, 0, -1, 0, -1);
    chk("wr_busy_len", 64'(busy_cycles), 7);
    chk("wr_keep_rd", 64'(core_rd_data), 64'h0000_0000_DEAD_BEEF);

    // flush on second REQ cycle
    access(1'b1, AW'($urandom), '0, DW'($urandom), 3, 0, 1, 0, 1, 0, -1);

    // flush during ACCESS is ignored
    access(1'b1, AW'($urandom), '0, DW'($urandom), 0, 1, 1, 0, -1, 1, -1);

    // timeout, then a good access clears the error
    access(1'b1, AW'($urandom), '0, DW'($urandom), 1, 9, 1, 0, -1, 0, -1);
    chk("to_err", 64'(core_err), 1);
    chk("to_rd", 64'(core_rd_data), 0);
    access(1'b0, AW'($urandom), DW'($urandom), DW'($urandom),
           0, 4, 1, 0, -1, 0, -1);
    chk("to_clear", 64'(core_err), 0);

    // stalled HOLD, flushed HOLD, reset mid-ACCESS
    access(1'b1, AW'($urandom), '0, DW'($urandom), 0, 0, 3, 0, -1, 0, -1);
    access(1'b1, AW'($urandom), '0, DW'($urandom), 1, 1, 3, 1, -1, 0, -1);
    access(1'b0, AW'($urandom), DW'($urandom), DW'($urandom),
           1, 3, 1, 0, -1, 0, 1);

    // randomized back-to-back accesses
    for (int t = 0; t < 40; t++) begin
      int gd;
      int fr;
      gd = int'($urandom_range(3, 0));
      fr = ($urandom_range(4, 0) == 0) ? int'($urandom_range(gd, 0)) : -1;
      access(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
             gd, int'($urandom_range(6, 0)), int'($urandom_range(3, 1)),
             1'($urandom), fr, 1'($urandom), -1);
      if ($urandom_range(3, 0) == 0) begin
        core_req = 1'b0;
        #1;
        chk("gap_busy", 64'(busy), 0);
        chk("gap_req", 64'(bus_req_), 1);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
